// File: rtl/alu_wide_seq_if.sv
// alu_wide_seq_if: request/response handshake bundle between the execute stage
// (master) and the wide-operand ALU sequencer (slave).
//   req_valid/req_ready  request handshake, payload req_op/req_a/req_b/req_cin
//   rsp_valid/rsp_ready  response handshake, payload rsp_result and rsp_c/z/v/s/err
interface alu_wide_seq_if #(
  parameter int WORDS = 2
);
  localparam int DW = 16 * WORDS;

  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_op;
  logic [DW-1:0] req_a;
  logic [DW-1:0] req_b;
  logic          req_cin;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_result;
  logic          rsp_c;
  logic          rsp_z;
  logic          rsp_v;
  logic          rsp_s;
  logic          rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_c, rsp_z, rsp_v, rsp_s, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_c, rsp_z, rsp_v, rsp_s, rsp_err
  );
endinterface

// File: rtl/alu_wide_seq.sv
// alu_wide_seq: runs WORDS*16-bit add/sub/logic operations on a single external
// 16-bit combinational ALU, one word per clock, least significant word first,
// chaining carry/borrow between words. The full-width result and flags are
// returned on a valid/ready response.
// Ports:
//   i_clk, i_rst        clock (rising edge), asynchronous active-high reset
//   bus (slave)         request/response handshake, see alu_wide_seq_if
//   o_alu_func/a/b/cin  drive to the ALU (idle code 1111 when not running)
//   i_alu_out/c/v       ALU result and carry/borrow, overflow
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// RUN    | one operand word per clock through the ALU
// ERR    | illegal op accepted; one cycle before the error response
// DONE   | response presented, held until rsp_ready
module alu_wide_seq #(
  parameter int WORDS = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  alu_wide_seq_if.slave bus,
  output logic [3:0]    o_alu_func,
  output logic [15:0]   o_alu_a,
  output logic [15:0]   o_alu_b,
  output logic          o_alu_cin,
  input  logic [15:0]   i_alu_out,
  input  logic          i_alu_c,
  input  logic          i_alu_v
);

  localparam int DW = 16 * WORDS;
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_ERR  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [2:0]    r_op;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic          r_carry;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_res;
  logic          r_zacc;

  logic [DW-1:0] r_rsp_result;
  logic          r_rsp_c;
  logic          r_rsp_z;
  logic          r_rsp_v;
  logic          r_rsp_s;
  logic          r_rsp_err;

  logic          w_accept;
  logic          w_req_legal;
  logic          w_req_arith;
  logic          w_arith;
  logic          w_last;
  logic          w_word_zero;
  logic [DW+15:0] w_cat;
  logic [DW-1:0] w_res_nxt;

  assign w_accept    = (r_state == S_IDLE) && bus.req_valid;
  assign w_req_legal = (bus.req_op <= OP_NOT);
  assign w_req_arith = (bus.req_op == OP_ADD) || (bus.req_op == OP_SUB);
  assign w_arith     = (r_op == OP_ADD) || (r_op == OP_SUB);
  assign w_last      = (r_cnt == '0);
  assign w_word_zero = (i_alu_out == 16'h0000);

  // Result words shift in from the top, so after WORDS captures the first
  // (least significant) word has reached bit 0.
  assign w_cat     = {i_alu_out, r_res};
  assign w_res_nxt = w_cat[DW+15:16];

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_state_nxt = w_req_legal ? S_RUN : S_ERR;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_ERR: begin
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (bus.rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ALU drive: only RUN touches the ALU; otherwise the idle function code
  // forces its outputs to zero.
  always_comb begin
    o_alu_func = 4'b1111;
    o_alu_a    = 16'h0000;
    o_alu_b    = 16'h0000;
    o_alu_cin  = 1'b0;
    if (r_state == S_RUN) begin
      o_alu_a   = r_a[15:0];
      o_alu_b   = r_b[15:0];
      o_alu_cin = w_arith & r_carry;
      case (r_op)
        OP_ADD:  o_alu_func = 4'b0000;
        OP_SUB:  o_alu_func = 4'b0001;
        OP_AND:  o_alu_func = 4'b0010;
        OP_OR:   o_alu_func = 4'b0011;
        OP_XOR:  o_alu_func = 4'b0100;
        OP_NOT:  o_alu_func = 4'b0111;
        default: o_alu_func = 4'b1111;
      endcase
    end
  end

  // Datapath: operand latch, per-word capture, response registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_op         <= 3'd0;
      r_a          <= '0;
      r_b          <= '0;
      r_carry      <= 1'b0;
      r_cnt        <= '0;
      r_res        <= '0;
      r_zacc       <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_c      <= 1'b0;
      r_rsp_z      <= 1'b0;
      r_rsp_v      <= 1'b0;
      r_rsp_s      <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= bus.req_op;
            r_a     <= bus.req_a;
            r_b     <= bus.req_b;
            // The carry register doubles as the word-0 carry-in.
            r_carry <= bus.req_cin & w_req_arith;
            r_cnt   <= CW'(WORDS - 1);
            r_res   <= '0;
            r_zacc  <= 1'b1;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> 16;
          r_b     <= r_b >> 16;
          r_carry <= i_alu_c;
          r_res   <= w_res_nxt;
          r_zacc  <= r_zacc & w_word_zero;
          r_cnt   <= r_cnt - 1'b1;
          if (w_last) begin
            r_rsp_result <= w_res_nxt;
            r_rsp_c      <= w_arith & i_alu_c;
            r_rsp_z      <= r_zacc & w_word_zero;
            r_rsp_v      <= i_alu_v;
            r_rsp_s      <= w_res_nxt[DW-1];
            r_rsp_err    <= 1'b0;
          end
        end
        S_ERR: begin
          r_rsp_err <= 1'b1;
        end
        S_DONE: begin
          if (bus.rsp_ready) begin
            r_rsp_result <= '0;
            r_rsp_c      <= 1'b0;
            r_rsp_z      <= 1'b0;
            r_rsp_v      <= 1'b0;
            r_rsp_s      <= 1'b0;
            r_rsp_err    <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.rsp_valid  = (r_state == S_DONE);
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_c      = r_rsp_c;
  assign bus.rsp_z      = r_rsp_z;
  assign bus.rsp_v      = r_rsp_v;
  assign bus.rsp_s      = r_rsp_s;
  assign bus.rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_alu_wide_seq.sv
// tb_alu_wide_seq: drives directed and random requests into alu_wide_seq
// (WORDS=2) with a behavioural 16-bit ALU attached; expected responses come
// from a full-width arithmetic model and are checked by a separate monitor.
module tb_alu_wide_seq;
  localparam int WORDS = 2;
  localparam int DW    = 16 * WORDS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_wide_seq_if #(.WORDS(WORDS)) bus ();

  logic [3:0]  alu_func;
  logic [15:0] alu_a, alu_b, alu_out;
  logic        alu_cin, alu_c, alu_v;
  logic [16:0] alu_t;

  alu_wide_seq #(.WORDS(WORDS)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .bus        (bus),
    .o_alu_func (alu_func),
    .o_alu_a    (alu_a),
    .o_alu_b    (alu_b),
    .o_alu_cin  (alu_cin),
    .i_alu_out  (alu_out),
    .i_alu_c    (alu_c),
    .i_alu_v    (alu_v)
  );

  // 16-bit combinational ALU
  always_comb begin
    alu_t   = '0;
    alu_out = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_func)
      4'h0: begin
        alu_t   = {1'b0, alu_b} + {1'b0, alu_a} + {16'b0, alu_cin};
        alu_out = alu_t[15:0];
        alu_c   = alu_t[16];
        alu_v   = (alu_a[15] == alu_b[15]) && (alu_t[15] != alu_b[15]);
      end
      4'h1: begin
        alu_t   = {1'b0, alu_b} - {1'b0, alu_a} - {16'b0, alu_cin};
        alu_out = alu_t[15:0];
        alu_c   = alu_t[16];
        alu_v   = (alu_a[15] != alu_b[15]) && (alu_t[15] != alu_b[15]);
      end
      4'h2: alu_out = alu_a & alu_b;
      4'h3: alu_out = alu_a | alu_b;
      4'h4: alu_out = alu_a ^ alu_b;
      4'h7: alu_out = ~alu_b;
      default: alu_out = '0;
    endcase
  end

  typedef struct packed {
    logic [DW-1:0] r;
    logic c, z, v, s, err;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic word1_cin;

  function automatic exp_t model(input logic [2:0] op, input logic [DW-1:0] a, b,
                                 input logic cin);
    logic [DW:0] w;
    exp_t e;
    e = '0;
    w = '0;
    case (op)
      3'd0: begin
        w   = {1'b0, b} + {1'b0, a} + {{DW{1'b0}}, cin};
        e.r = w[DW-1:0];
        e.c = w[DW];
        e.v = (a[DW-1] == b[DW-1]) && (e.r[DW-1] != b[DW-1]);
      end
      3'd1: begin
        w   = {1'b0, b} - {1'b0, a} - {{DW{1'b0}}, cin};
        e.r = w[DW-1:0];
        e.c = w[DW];
        e.v = (a[DW-1] != b[DW-1]) && (e.r[DW-1] != b[DW-1]);
      end
      3'd2: e.r = a & b;
      3'd3: e.r = a | b;
      3'd4: e.r = a ^ b;
      3'd5: e.r = ~b;
      default: e.err = 1'b1;
    endcase
    if (!e.err) begin
      e.z = (e.r == '0);
      e.s = e.r[DW-1];
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compares every response as it is accepted
  exp_t m_e;
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_rsp", {63'd0, bus.rsp_valid}, 64'd0);
      end else begin
        m_e = q.pop_front();
        chk("rsp_result", 64'(bus.rsp_result), 64'(m_e.r));
        chk("rsp_flags_czvse",
            {59'd0, bus.rsp_c, bus.rsp_z, bus.rsp_v, bus.rsp_s, bus.rsp_err},
            {59'd0, m_e.c, m_e.z, m_e.v, m_e.s, m_e.err});
      end
    end
  end

  task automatic wait_ready();
    int w;
    @(negedge clk);
    w = 0;
    while (!bus.req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!bus.req_ready) chk("req_ready_timeout", {63'd0, bus.req_ready}, 64'd1);
  endtask

  task automatic issue(input logic [2:0] op, input logic [DW-1:0] a, b,
                       input logic cin, input int hold);
    int lat;
    int exp_lat;
    logic [DW+5:0] snap;
    exp_t e;
    e = model(op, a, b, cin);
    exp_lat = (op <= 3'd5) ? WORDS + 1 : 2;
    wait_ready();
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_cin   = cin;
    bus.req_valid = 1'b1;
    q.push_back(e);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    word1_cin = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 2) word1_cin = alu_cin;
    end while (!bus.rsp_valid && lat < 20);
    chk("latency", 64'(lat), 64'(exp_lat));
    snap = {bus.rsp_valid, bus.rsp_result, bus.rsp_c, bus.rsp_z, bus.rsp_v,
            bus.rsp_s, bus.rsp_err};
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_stable", 64'({bus.rsp_valid, bus.rsp_result, bus.rsp_c, bus.rsp_z,
                              bus.rsp_v, bus.rsp_s, bus.rsp_err}), 64'(snap));
      chk("hold_req_ready", {63'd0, bus.req_ready}, 64'd0);
      chk("hold_alu_func", {60'd0, alu_func}, 64'hF);
    end
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    chk("post_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("post_rsp_cleared", 64'({bus.rsp_result, bus.rsp_c, bus.rsp_z, bus.rsp_v,
                                 bus.rsp_s, bus.rsp_err}), 64'd0);
    chk("post_req_ready", {63'd0, bus.req_ready}, 64'd1);
  endtask

  function automatic logic [DW-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return DW'(32'h0000_FFFF);
      default: return DW'($urandom());
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = 1'b0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", {63'd0, bus.req_ready}, 64'd1);
    chk("reset_rsp", 64'({bus.rsp_valid, bus.rsp_result, bus.rsp_c, bus.rsp_z,
                          bus.rsp_v, bus.rsp_s, bus.rsp_err}), 64'd0);
    chk("reset_alu_drive", 64'({alu_func, alu_a, alu_b, alu_cin}), 64'({4'hF, 33'd0}));

    issue(3'd0, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 0);
    issue(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    chk("add_word1_cin", {63'd0, word1_cin}, 64'd1);
    issue(3'd1, 32'h0000_0001, 32'h0000_0000, 1'b0, 0);
    issue(3'd1, 32'h0000_0001, 32'h0001_0000, 1'b0, 1);
    issue(3'd5, 32'h0BAD_F00D, 32'h1234_5678, 1'b1, 0);
    issue(3'd4, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b0, 0);
    issue(3'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1, 0);
    issue(3'd3, 32'h8000_0000, 32'h0000_0001, 1'b0, 0);
    issue(3'd0, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 5);
    issue(3'd6, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 2);
    issue(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);

    // Reset in the middle of word 1: response must be dropped
    wait_ready();
    bus.req_op    = 3'd0;
    bus.req_a     = 32'h1111_2222;
    bus.req_b     = 32'h3333_4444;
    bus.req_cin   = 1'b0;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #1 chk("rst_mid_alu_func", {60'd0, alu_func}, 64'd0);
    rst = 1'b1;
    #1;
    chk("rst_mid_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("rst_mid_req_ready", {63'd0, bus.req_ready}, 64'd1);
    chk("rst_mid_alu_func_idle", {60'd0, alu_func}, 64'hF);
    @(negedge clk);
    rst = 1'b0;
    issue(3'd0, 32'h0000_0001, 32'h0000_0001, 1'b0, 0);

    for (int n = 0; n < 60; n++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 2)));
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
